// File: rtl/uart_tx_device.sv
// uart_tx_device: memory-mapped 8N1 UART transmitter with a small byte FIFO.
// Bus stores fill the FIFO; a four-state FSM serialises frames at DIVIDER clocks per bit.
module uart_tx_device #(
    parameter logic [15:0] BASE_ADDRESS    = 16'hFF00,
    parameter int          FIFO_DEPTH_LOG2 = 2,
    parameter logic [15:0] DEFAULT_DIVIDER = 16'd868
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        write_enable,
    input  logic [15:0] write_address,
    input  logic [15:0] data_in,
    input  logic [15:0] read_address,
    output logic [15:0] data_out,
    output logic        tx,
    output logic        irq_empty
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PW    = FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;

    localparam logic [1:0] OFF_STATUS  = 2'd0;
    localparam logic [1:0] OFF_TXDATA  = 2'd1;
    localparam logic [1:0] OFF_DIVIDER = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t state, state_nx;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;

    logic [15:0] divider;
    logic [15:0] period, period_nx;
    logic [15:0] timer, timer_nx;
    logic [7:0]  shift, shift_nx;
    logic [2:0]  bit_idx, bit_idx_nx;
    logic        tx_q, tx_nx;
    logic [15:0] rdata_q, rdata_nx;

    logic       w_hit, r_hit;
    logic [1:0] w_off, r_off;
    logic       push_req, push, pop;
    logic       full, empty, busy, bit_end;
    logic       ovf_clr, div_wr;
    logic [3:0] count4;
    logic [15:0] status;

    // ---------------------------------------------------------------
    // Bus decode
    // ---------------------------------------------------------------
    assign w_hit = write_enable
                && (write_address[15:2] == BASE_ADDRESS[15:2]);
    assign r_hit = (read_address[15:2] == BASE_ADDRESS[15:2]);
    assign w_off = write_address[1:0];
    assign r_off = read_address[1:0];

    assign push_req = w_hit && (w_off == OFF_TXDATA);
    assign div_wr   = w_hit && (w_off == OFF_DIVIDER);
    assign ovf_clr  = w_hit && (w_off == OFF_STATUS) && data_in[3];

    // A full FIFO still accepts a byte when the FSM frees a slot this cycle.
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign push  = push_req && (!full || pop);

    assign busy    = (state != S_IDLE);
    assign bit_end = (timer == 16'd0);

    assign count4 = 4'(count);
    assign status = {8'h00, count4, overflow, empty, full, busy};

    // ---------------------------------------------------------------
    // Transmit FSM: next state, datapath and pop
    // ---------------------------------------------------------------
    always_comb begin
        state_nx   = state;
        timer_nx   = timer;
        shift_nx   = shift;
        bit_idx_nx = bit_idx;
        period_nx  = period;
        pop        = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    shift_nx  = mem[rd_ptr];
                    period_nx = divider;
                    timer_nx  = divider - 16'd1;
                    state_nx  = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    bit_idx_nx = 3'd0;
                    timer_nx   = period - 16'd1;
                    state_nx   = S_DATA;
                end else begin
                    timer_nx = timer - 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_nx = {1'b0, shift[7:1]};
                    timer_nx = period - 16'd1;
                    if (bit_idx == 3'd7) begin
                        state_nx = S_STOP;
                    end else begin
                        bit_idx_nx = bit_idx + 3'd1;
                    end
                end else begin
                    timer_nx = timer - 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        shift_nx  = mem[rd_ptr];
                        period_nx = divider;
                        timer_nx  = divider - 16'd1;
                        state_nx  = S_START;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end else begin
                    timer_nx = timer - 16'd1;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // The line level is decided from the next state so tx can be a flop.
    always_comb begin
        tx_nx = 1'b1;
        unique case (state_nx)
            S_IDLE:  tx_nx = 1'b1;
            S_START: tx_nx = 1'b0;
            S_DATA:  tx_nx = shift_nx[0];
            S_STOP:  tx_nx = 1'b1;
            default: tx_nx = 1'b1;
        endcase
    end

    // ---------------------------------------------------------------
    // Read mux (values before any same-cycle write)
    // ---------------------------------------------------------------
    always_comb begin
        rdata_nx = 16'h0000;
        if (r_hit) begin
            unique case (r_off)
                OFF_STATUS:  rdata_nx = status;
                OFF_DIVIDER: rdata_nx = divider;
                default:     rdata_nx = 16'h0000;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            divider  <= DEFAULT_DIVIDER;
            period   <= DEFAULT_DIVIDER;
            timer    <= 16'd0;
            shift    <= 8'h00;
            bit_idx  <= 3'd0;
            tx_q     <= 1'b1;
            rdata_q  <= 16'h0000;
        end else begin
            state   <= state_nx;
            period  <= period_nx;
            timer   <= timer_nx;
            shift   <= shift_nx;
            bit_idx <= bit_idx_nx;
            tx_q    <= tx_nx;
            rdata_q <= rdata_nx;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end

            if (ovf_clr) begin
                overflow <= 1'b0;
            end else if (push_req && full && !pop) begin
                overflow <= 1'b1;
            end

            if (div_wr) begin
                divider <= (data_in == 16'd0) ? 16'd1 : data_in;
            end
        end
    end

    // Storage needs no reset; count and pointers define what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= data_in[7:0];
        end
    end

    assign data_out  = rdata_q;
    assign tx        = tx_q;
    assign irq_empty = empty && (state == S_IDLE);

endmodule

// File: tb/tb_uart_tx_device.sv
// tb_uart_tx_device: scoreboard bench; queued expected bytes are checked
// against the serial line by a frame monitor, queued reads by a read monitor.
module tb_uart_tx_device;

    localparam logic [15:0] BASE = 16'hFF00;

    logic        clock;
    logic        reset;
    logic        write_enable;
    logic [15:0] write_address;
    logic [15:0] data_in;
    logic [15:0] read_address;
    logic [15:0] data_out;
    logic        tx;
    logic        irq_empty;

    uart_tx_device dut (
        .clock         (clock),
        .reset         (reset),
        .write_enable  (write_enable),
        .write_address (write_address),
        .data_in       (data_in),
        .read_address  (read_address),
        .data_out      (data_out),
        .tx            (tx),
        .irq_empty     (irq_empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int mdl_div = 868;

    logic [7:0]  exp_q[$];
    logic [15:0] rd_exp_q[$];
    string       rd_name_q[$];
    int          starts[$];
    logic        rd_req = 1'b0;
    logic        rd_took = 1'b0;

    bit         in_frame = 1'b0;
    bit         f_ok;
    int         f_t;
    int         f_p;
    logic [9:0] f_bits;
    logic [9:0] obs;
    logic [7:0] f_byte;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Frame monitor: a frame is 10 bits (0, data LSB first, 1), each mdl_div
    // cycles long, using the divider in force when the frame begins.
    always @(negedge clock) begin
        if (reset) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame && tx !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_start", 32'(tx), 32'd1);
                end else begin
                    f_byte   = exp_q.pop_front();
                    f_bits   = {1'b1, f_byte, 1'b0};
                    f_p      = mdl_div;
                    f_t      = 0;
                    f_ok     = 1'b1;
                    obs      = '0;
                    in_frame = 1'b1;
                    starts.push_back(cyc);
                end
            end
            if (in_frame) begin
                if (tx !== f_bits[f_t / f_p]) f_ok = 1'b0;
                if (f_t % f_p == f_p / 2) obs[f_t / f_p] = tx;
                f_t++;
                if (f_t == 10 * f_p) begin
                    in_frame = 1'b0;
                    chk($sformatf("frame_%02h_p%0d", f_byte, f_p),
                        {21'd0, ~f_ok, obs}, {22'd0, f_bits});
                end
            end
        end
    end

    // Read monitor: data_out after the edge that sampled a queued read.
    always @(posedge clock) rd_took <= rd_req;

    always @(negedge clock) begin
        if (rd_took) begin
            if (rd_exp_q.size() == 0)
                chk("rd_queue_underflow", 32'd1, 32'd0);
            else
                chk(rd_name_q.pop_front(), 32'(data_out),
                    32'(rd_exp_q.pop_front()));
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic wr(input logic [15:0] addr, input logic [15:0] d);
        write_enable  = 1'b1;
        write_address = addr;
        data_in       = d;
        @(posedge clock); #1;
        write_enable  = 1'b0;
    endtask

    task automatic rd(input logic [15:0] addr, input logic [15:0] exp,
                      input string name);
        read_address = addr;
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(name);
        rd_req = 1'b1;
        @(posedge clock); #1;
        rd_req = 1'b0;
    endtask

    task automatic wr_div(input logic [15:0] v);
        wr(BASE + 16'd2, v);
        mdl_div = (v == 16'd0) ? 1 : int'(v);
    endtask

    task automatic send(input logic [7:0] b);
        exp_q.push_back(b);
        wr(BASE + 16'd1, {8'h00, b});
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (!(irq_empty === 1'b1 && !in_frame) && n < bound) begin
            @(posedge clock); #1;
            n++;
        end
        chk("wait_idle", 32'(irq_empty === 1'b1 && !in_frame), 32'd1);
    endtask

    task automatic check_gaps(input int want, input int nframes,
                              input string name);
        chk({name, "_count"}, 32'(starts.size()), 32'(nframes));
        for (int i = 1; i < starts.size(); i++)
            chk(name, 32'(starts[i] - starts[i-1]), 32'(want));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        write_enable  = 1'b0;
        write_address = 16'h0000;
        data_in       = 16'h0000;
        read_address  = 16'h0000;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_irq_empty", 32'(irq_empty), 32'd1);
        rd(BASE, 16'h0004, "reset_status");
        rd(BASE + 16'd2, 16'd868, "reset_divider");
        rd(BASE + 16'd1, 16'h0000, "txdata_read");
        rd(BASE + 16'd3, 16'h0000, "reserved_read");
        rd(16'h1235, 16'h0000, "miss_read");
        wr(16'h1231, 16'h0077);
        wr(BASE + 16'd3, 16'h00FF);
        rd(BASE, 16'h0004, "status_after_ignored_writes");

        // Single frame, exact latency and irq timing
        wr_div(16'd4);
        send(8'hA5);
        chk("tx_before_pop", 32'(tx), 32'd1);
        @(posedge clock); #1;
        chk("tx_after_pop", 32'(tx), 32'd0);
        chk("irq_busy", 32'(irq_empty), 32'd0);
        repeat (39) @(posedge clock);
        #1;
        chk("irq_at_39", 32'(irq_empty), 32'd0);
        @(posedge clock); #1;
        chk("irq_at_40", 32'(irq_empty), 32'd1);
        wait_idle(20);

        // Burst of five into a depth-4 FIFO, then overflow
        wr_div(16'd2);
        starts.delete();
        for (int i = 0; i < 5; i++) send(8'($urandom));
        rd(BASE, 16'h0043, "status_full");
        wr(BASE + 16'd1, 16'h00EE);
        rd(BASE, 16'h004B, "status_overflow");
        wr(BASE, 16'h0008);
        rd(BASE, 16'h0043, "status_ovf_cleared");
        wait_idle(300);
        check_gaps(20, 5, "burst_gap");
        rd(BASE, 16'h0004, "status_after_burst");

        // Divider 0 is stored as 1
        wr_div(16'd0);
        rd(BASE + 16'd2, 16'd1, "divider_zero");
        starts.delete();
        send(8'h96);
        send(8'h0F);
        wait_idle(100);
        check_gaps(10, 2, "div1_gap");

        // Divider change mid-frame applies to the next frame only
        wr_div(16'd2);
        starts.delete();
        send(8'h3C);
        send(8'h5A);
        repeat (6) @(posedge clock);
        #1;
        wr_div(16'd3);
        wait_idle(200);
        check_gaps(20, 2, "midframe_gap");

        // Read and write of DIVIDER in the same cycle
        write_enable  = 1'b1;
        write_address = BASE + 16'd2;
        data_in       = 16'd5;
        rd(BASE + 16'd2, 16'd3, "rw_same_cycle");
        write_enable  = 1'b0;
        mdl_div       = 5;
        rd(BASE + 16'd2, 16'd5, "divider_after_rw");

        // Reset in the middle of a frame
        wr_div(16'd4);
        send(8'hC3);
        repeat (12) @(posedge clock);
        #1;
        reset = 1'b1;
        exp_q.delete();
        mdl_div = 868;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("tx_after_reset", 32'(tx), 32'd1);
        rd(BASE, 16'h0004, "status_after_reset");
        rd(BASE + 16'd2, 16'd868, "divider_after_reset");
        repeat (40) @(posedge clock);
        #1;
        chk("quiet_tx", 32'(tx), 32'd1);
        chk("quiet_irq", 32'(irq_empty), 32'd1);

        // Randomised bursts
        for (int it = 0; it < 6; it++) begin
            int n;
            wr_div(16'($urandom_range(1, 5)));
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) send(8'($urandom));
            wait_idle(300);
            rd(BASE, 16'h0004, "status_after_random");
        end

        @(posedge clock); #1;
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("rd_q_drained", 32'(rd_exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
